max_pool_1d: RTL and testbench

- Non-overlapping 1D max-pooling stage. It sits directly downstream of the ReLU activation in the cnn1d pipeline.
- Consumes a stream of DATA_WIDTH-bit samples and emits one sample per window of POOL_SIZE inputs: the signed maximum of that window.
- Uses the pipeline's valid/ready handshake on both sides.
- An optional end-of-frame marker closes a partial window early, so frame lengths need not be multiples of POOL_SIZE.

---
 rtl/max_pool_1d.sv | 83 ++++++++
 tb/tb_max_pool_1d.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_1d.sv
// Non-overlapping 1D signed max-pooling stage with valid/ready on both sides.
// An end-of-frame marker on the input closes a partial window early.

package cnn1d_pkg;
    localparam int DATA_WIDTH = 12;
endpackage

module max_pool_1d #(
    parameter int DATA_WIDTH = cnn1d_pkg::DATA_WIDTH,
    parameter int POOL_SIZE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  pool_ready_in,
    input  logic                  pool_valid_in,
    input  logic [DATA_WIDTH-1:0] pool_data_in,
    input  logic                  pool_last_in,
    input  logic                  pool_ready_out,
    output logic                  pool_valid_out,
    output logic [DATA_WIDTH-1:0] pool_data_out,
    output logic                  pool_last_out
);

    localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_SIZE - 1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]             r_cnt;
    logic signed [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]        r_data;
    logic                         r_valid;
    logic                         r_last;

    logic                         w_closing;
    logic                         w_ready;
    logic                         w_accept;
    logic                         w_close_accept;
    logic signed [DATA_WIDTH-1:0] w_sample;
    logic signed [DATA_WIDTH-1:0] w_max;

    // Only a window-closing sample needs room in the output register.
    assign w_closing      = (r_cnt == LAST_CNT) | pool_last_in;
    assign w_ready        = ~rst & (~w_closing | ~r_valid | pool_ready_out);
    assign w_accept       = pool_valid_in & w_ready;
    assign w_close_accept = w_accept & w_closing;

    assign w_sample = $signed(pool_data_in);
    assign w_max    = (w_sample > r_acc) ? w_sample : r_acc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= MOST_NEG;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_close_accept) begin
                r_data  <= w_max;
                r_last  <= pool_last_in;
                r_valid <= 1'b1;
                r_acc   <= MOST_NEG;
                r_cnt   <= '0;
            end else begin
                if (w_accept) begin
                    r_acc <= w_max;
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_valid & pool_ready_out) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign pool_ready_in  = w_ready;
    assign pool_valid_out = r_valid;
    assign pool_data_out  = r_data;
    assign pool_last_out  = r_last;

endmodule

// File: tb/tb_max_pool_1d.sv
// Bench for max_pool_1d: four instances (POOL_SIZE 1..4) checked every cycle
// against a window-list model, plus directed vectors with literal expectations.

module tb_max_pool_1d;

    localparam int DW = 12;
    localparam int NI = 4;   // instance k has POOL_SIZE k+1

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0] vin     = '0;
    logic [NI-1:0] lin     = '0;
    logic [NI-1:0] rdy_out = '1;
    logic [DW-1:0] din [NI];
    wire  [NI-1:0] rin;
    wire  [NI-1:0] vout;
    wire  [NI-1:0] lout;
    wire  [DW-1:0] dout [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        max_pool_1d #(.DATA_WIDTH(DW), .POOL_SIZE(g + 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .pool_ready_in  (rin[g]),
            .pool_valid_in  (vin[g]),
            .pool_data_in   (din[g]),
            .pool_last_in   (lin[g]),
            .pool_ready_out (rdy_out[g]),
            .pool_valid_out (vout[g]),
            .pool_data_out  (dout[g]),
            .pool_last_out  (lout[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: samples of the open window, the output register, and a log of transfers.
    bit                   checking = 1'b0;
    bit                   m_valid [NI];
    bit                   m_last  [NI];
    logic [DW-1:0]        m_data  [NI];
    logic signed [DW-1:0] win     [NI][$];
    logic [DW:0]          olog    [NI][$];

    initial begin
        for (int k = 0; k < NI; k++) begin
            din[k]    = '0;
            m_valid[k] = 1'b0;
            m_last[k]  = 1'b0;
            m_data[k]  = '0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NI; k++) begin
                bit closing, exp_rdy, xfer, acc;
                logic signed [DW-1:0] mx;
                check($sformatf("valid_out[%0d]", k), 32'(vout[k]), 32'(m_valid[k]));
                check($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(m_data[k]));
                check($sformatf("last_out[%0d]", k), 32'(lout[k]), 32'(m_last[k]));
                closing = (win[k].size() == k) || lin[k];
                exp_rdy = !rst && (!closing || !m_valid[k] || rdy_out[k]);
                check($sformatf("ready_in[%0d]", k), 32'(rin[k]), 32'(exp_rdy));
                if (rst) begin
                    m_valid[k] = 1'b0;
                    m_last[k]  = 1'b0;
                    m_data[k]  = '0;
                    win[k].delete();
                end else begin
                    xfer = m_valid[k] && rdy_out[k];
                    acc  = vin[k] && exp_rdy;
                    if (xfer) begin
                        olog[k].push_back({m_last[k], m_data[k]});
                        m_valid[k] = 1'b0;
                    end
                    if (acc) begin
                        win[k].push_back($signed(din[k]));
                        if (closing) begin
                            mx = win[k][0];
                            foreach (win[k][i]) if (win[k][i] > mx) mx = win[k][i];
                            m_data[k]  = mx;
                            m_last[k]  = lin[k];
                            m_valid[k] = 1'b1;
                            win[k].delete();
                        end
                    end
                end
            end
        end
    end

    function automatic logic [DW:0] log_at(input int k, input int i);
        if (i < olog[k].size()) return olog[k][i];
        return '1;
    endfunction

    // Present one sample and hold it until the instance accepts it.
    task automatic send(input int k, input logic [DW-1:0] d, input logic l);
        bit a;
        int n;
        vin[k] = 1'b1;
        din[k] = d;
        lin[k] = l;
        n = 0;
        do begin
            @(negedge clk);
            a = rin[k];
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 50);
        check($sformatf("send accepted[%0d]", k), 32'(a), 32'd1);
        vin[k] = 1'b0;
        lin[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v1 [8];
        logic [DW-1:0] v3 [7];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset valid_out", 32'(vout[k]), 32'd0);
            check("reset data_out", 32'(dout[k]), 32'd0);
            check("reset ready_in", 32'(rin[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Basic pooling, POOL_SIZE=4
        olog[3].delete();
        v1 = '{12'd5, 12'd17, 12'd3, 12'd9, 12'd0, 12'd2, 12'd2, 12'd1};
        foreach (v1[i]) send(3, v1[i], 1'b0);
        idle(3);
        check("basic count", 32'(olog[3].size()), 32'd2);
        check("basic out0", 32'(log_at(3, 0)), 32'h011);
        check("basic out1", 32'(log_at(3, 1)), 32'h002);

        // Signed values, POOL_SIZE=2
        olog[1].delete();
        send(1, 12'hFFE, 1'b0);
        send(1, 12'hFFF, 1'b0);
        send(1, 12'h800, 1'b0);
        send(1, 12'h7FF, 1'b0);
        idle(3);
        check("signed count", 32'(olog[1].size()), 32'd2);
        check("signed out0", 32'(log_at(1, 0)), 32'h0FFF);
        check("signed out1", 32'(log_at(1, 1)), 32'h07FF);

        // Partial frame, POOL_SIZE=4
        olog[3].delete();
        v3 = '{12'd7, 12'd30, 12'd12, 12'd4, 12'd6, 12'd1, 12'd8};
        foreach (v3[i]) send(3, v3[i], i == 2);
        idle(3);
        check("partial count", 32'(olog[3].size()), 32'd2);
        check("partial out0", 32'(log_at(3, 0)), 32'h101E);
        check("partial out1", 32'(log_at(3, 1)), 32'h0008);

        // Backpressure, POOL_SIZE=2
        olog[1].delete();
        rdy_out[1] = 1'b0;
        send(1, 12'd4, 1'b0);
        send(1, 12'd9, 1'b0);
        send(1, 12'd1, 1'b0);
        vin[1] = 1'b1;
        din[1] = 12'd6;
        repeat (3) begin
            @(negedge clk);
            check("bp ready held low", 32'(rin[1]), 32'd0);
            check("bp valid held", 32'(vout[1]), 32'd1);
            check("bp data held", 32'(dout[1]), 32'd9);
        end
        @(posedge clk);
        #1;
        rdy_out[1] = 1'b1;
        @(negedge clk);
        check("bp ready on release", 32'(rin[1]), 32'd1);
        @(posedge clk);
        #1;
        vin[1] = 1'b0;
        @(negedge clk);
        check("bp next valid", 32'(vout[1]), 32'd1);
        check("bp next data", 32'(dout[1]), 32'd6);
        idle(3);
        check("bp count", 32'(olog[1].size()), 32'd2);
        check("bp out0", 32'(log_at(1, 0)), 32'h009);
        check("bp out1", 32'(log_at(1, 1)), 32'h006);

        // Reset mid-window, POOL_SIZE=4
        olog[3].delete();
        send(3, 12'd100, 1'b0);
        send(3, 12'd50, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst ready_in", 32'(rin[3]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst valid_out", 32'(vout[3]), 32'd0);
        check("post-rst data_out", 32'(dout[3]), 32'd0);
        check("post-rst last_out", 32'(lout[3]), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) send(3, DW'(i), 1'b0);
        idle(3);
        check("rst count", 32'(olog[3].size()), 32'd1);
        check("rst out0", 32'(log_at(3, 0)), 32'h004);

        // Random soak on every instance
        for (int k = 0; k < NI; k++) olog[k].delete();
        for (int c = 0; c < 20000; c++) begin
            for (int k = 0; k < NI; k++) begin
                vin[k]     = ($urandom_range(0, 99) < 60);
                din[k]     = DW'($urandom);
                lin[k]     = ($urandom_range(0, 99) < 5);
                rdy_out[k] = ($urandom_range(0, 99) < 70);
            end
            @(posedge clk);
            #1;
        end
        vin = '0;
        lin = '0;
        rdy_out = '1;
        idle(5);
        for (int k = 0; k < NI; k++)
            check($sformatf("soak activity[%0d]", k), 32'(olog[k].size() > 1000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
